// File: rtl/snn_mem_pkg.sv
// Shared definitions for the SNN matrix memory engines: widths, FSM encoding
// and the signed 16-bit saturation limits.
package snn_mem_pkg;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 16;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        WRITE
    } state_e;

endpackage

// File: rtl/matrix_spike_current_if.sv
// Start/done handshake plus the S, W and C memory ports of matrix_spike_current.
// The engine uses the master view; memories and the launcher use the slave view.
interface matrix_spike_current_if
    import snn_mem_pkg::*;
#(
    parameter int ADDR_W = snn_mem_pkg::ADDR_W,
    parameter int DATA_W = snn_mem_pkg::DATA_W
);
    logic                     start;
    logic                     done;
    logic        [ADDR_W-1:0] spike_start_address;
    logic        [ADDR_W-1:0] weight_start_address;
    logic        [ADDR_W-1:0] dest_start_address;
    logic        [9:0]        m_size;
    logic        [9:0]        k_size;
    logic        [5:0]        n_size;
    logic        [ADDR_W-1:0] spike_address;
    logic        [DATA_W-1:0] spike_readdata;
    logic        [ADDR_W-1:0] weight_address;
    logic signed [DATA_W-1:0] weight_readdata;
    logic        [ADDR_W-1:0] dest_address;
    logic signed [DATA_W-1:0] dest_writedata;
    logic                     dest_write_en;

    modport master (
        input  start, spike_start_address, weight_start_address, dest_start_address,
               m_size, k_size, n_size, spike_readdata, weight_readdata,
        output done, spike_address, weight_address, dest_address,
               dest_writedata, dest_write_en
    );

    modport slave (
        output start, spike_start_address, weight_start_address, dest_start_address,
               m_size, k_size, n_size, spike_readdata, weight_readdata,
        input  done, spike_address, weight_address, dest_address,
               dest_writedata, dest_write_en
    );

endinterface

// File: rtl/matrix_spike_current_spike_mac_sat.sv
// Spike-gated accumulator for one output element: a one-cycle valid pipe aligns
// the add with synchronous-read data; the next-value is saturated to DATA_W.
module spike_mac_sat
    import snn_mem_pkg::*;
#(
    parameter int DATA_W = snn_mem_pkg::DATA_W,
    parameter int ACC_W  = 26
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     iss_i,
    input  logic                     spike_i,
    input  logic signed [DATA_W-1:0] weight_i,
    output logic signed [DATA_W-1:0] sat_o
);
    logic                    vld_p1_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] w_ext;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (int'(v) > SAT_MAX) begin
            return DATA_W'(SAT_MAX);
        end else if (int'(v) < SAT_MIN) begin
            return DATA_W'(SAT_MIN);
        end else begin
            return v[DATA_W-1:0];
        end
    endfunction

    assign w_ext = {{(ACC_W-DATA_W){weight_i[DATA_W-1]}}, weight_i};

    always_comb begin
        acc_d = acc_q;
        if (vld_p1_q && spike_i) begin
            acc_d = acc_q + w_ext;
        end
    end

    // The saturated view includes this cycle's add so DRAIN can register it directly.
    assign sat_o = sat(acc_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1_q <= 1'b0;
            acc_q    <= '0;
        end else begin
            vld_p1_q <= iss_i;
            acc_q    <= clear_i ? '0 : acc_d;
        end
    end

endmodule

// File: rtl/matrix_spike_current.sv
// Computes C = S x W (binary spikes gating signed weights) one element at a time,
// K+2 cycles per element, writing saturated 16-bit currents row-major.
module matrix_spike_current
    import snn_mem_pkg::*;
#(
    parameter int ADDR_W = snn_mem_pkg::ADDR_W,
    parameter int DATA_W = snn_mem_pkg::DATA_W,
    parameter int ACC_W  = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    matrix_spike_current_if.master bus
);
    state_e                   state_q;
    logic                     done_q;
    logic                     wen_q;
    logic                     iss_q;
    logic signed [DATA_W-1:0] wdata_q;
    logic signed [DATA_W-1:0] sat_w;
    logic        [ADDR_W-1:0] spike_addr_q, weight_addr_q, dest_addr_q;
    logic        [ADDR_W-1:0] s_row_q, w_col_q, wbase_q, dptr_q;
    logic        [9:0]        m_q, ksz_q, i_q, k_q;
    logic        [5:0]        n_q, j_q;
    logic        [ADDR_W-1:0] k_step, n_step;
    logic                     clr, k_last, j_last, i_last, size_zero;

    assign k_step    = ADDR_W'(ksz_q);
    assign n_step    = ADDR_W'(n_q);
    assign k_last    = (k_q == ksz_q - 10'd1);
    assign j_last    = (j_q == n_q - 6'd1);
    assign i_last    = (i_q == m_q - 10'd1);
    assign size_zero = (bus.m_size == '0) || (bus.k_size == '0) || (bus.n_size == '0);
    assign clr       = (state_q == LOAD) || (state_q == WRITE);

    spike_mac_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clr),
        .iss_i    (iss_q),
        .spike_i  (bus.spike_readdata[0]),
        .weight_i (bus.weight_readdata),
        .sat_o    (sat_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            done_q        <= 1'b1;
            wen_q         <= 1'b0;
            wdata_q       <= '0;
            iss_q         <= 1'b0;
            spike_addr_q  <= bus.spike_start_address;
            weight_addr_q <= bus.weight_start_address;
            dest_addr_q   <= bus.dest_start_address;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
        end else begin
            wen_q <= 1'b0;
            iss_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= LOAD;
                        done_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    m_q     <= bus.m_size;
                    ksz_q   <= bus.k_size;
                    n_q     <= bus.n_size;
                    wbase_q <= bus.weight_start_address;
                    if (size_zero) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        i_q           <= '0;
                        j_q           <= '0;
                        k_q           <= '0;
                        s_row_q       <= bus.spike_start_address;
                        w_col_q       <= bus.weight_start_address;
                        dptr_q        <= bus.dest_start_address;
                        spike_addr_q  <= bus.spike_start_address;
                        weight_addr_q <= bus.weight_start_address;
                        iss_q         <= 1'b1;
                        state_q       <= MAC;
                    end
                end
                MAC: begin
                    // Walk along row i of S (+1) and down column j of W (+N).
                    if (!k_last) begin
                        k_q           <= k_q + 10'd1;
                        spike_addr_q  <= spike_addr_q + 1'b1;
                        weight_addr_q <= weight_addr_q + n_step;
                        iss_q         <= 1'b1;
                    end else begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    dest_addr_q <= dptr_q;
                    wdata_q     <= sat_w;
                    wen_q       <= 1'b1;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    dptr_q <= dptr_q + 1'b1;
                    k_q    <= '0;
                    if (!j_last) begin
                        j_q           <= j_q + 6'd1;
                        w_col_q       <= w_col_q + 1'b1;
                        weight_addr_q <= w_col_q + 1'b1;
                        spike_addr_q  <= s_row_q;
                        iss_q         <= 1'b1;
                        state_q       <= MAC;
                    end else if (!i_last) begin
                        j_q           <= '0;
                        i_q           <= i_q + 10'd1;
                        w_col_q       <= wbase_q;
                        weight_addr_q <= wbase_q;
                        s_row_q       <= s_row_q + k_step;
                        spike_addr_q  <= s_row_q + k_step;
                        iss_q         <= 1'b1;
                        state_q       <= MAC;
                    end else begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.done           = done_q;
    assign bus.spike_address  = spike_addr_q;
    assign bus.weight_address = weight_addr_q;
    assign bus.dest_address   = dest_addr_q;
    assign bus.dest_writedata = wdata_q;
    assign bus.dest_write_en  = wen_q;

endmodule

// File: tb/tb_matrix_spike_current.sv
// Bench for matrix_spike_current: directed vector table, hand-written corner
// sequences and randomized jobs checked against a plain matrix-product model.
module tb_matrix_spike_current;

    localparam int AW    = 14;
    localparam int MEMSZ = 1 << AW;

    typedef struct {
        int m;
        int k;
        int n;
        int s[6];
        int w[6];
        int c[4];
        int cyc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    matrix_spike_current_if #(.ADDR_W(AW), .DATA_W(16)) bus();

    matrix_spike_current #(.ADDR_W(AW), .DATA_W(16), .ACC_W(26)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] spike_mem  [MEMSZ];
    logic [15:0] weight_mem [MEMSZ];

    // Synchronous-read memories: data follows the address by one cycle.
    always @(posedge clk) begin
        bus.spike_readdata  <= spike_mem[bus.spike_address];
        bus.weight_readdata <= weight_mem[bus.weight_address];
    end

    int wr_a[$];
    int wr_d[$];

    always @(negedge clk) begin
        if (bus.dest_write_en === 1'b1) begin
            wr_a.push_back(int'(bus.dest_address));
            wr_d.push_back(int'(bus.dest_writedata));
        end
    end

    int   checks   = 0;
    int   failures = 0;
    int   model_s[64];
    int   model_w[64];
    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input int m, input int k, input int n, input int sb, input int wb);
        for (int idx = 0; idx < m * k; idx++) spike_mem[(sb + idx) % MEMSZ] = 16'(model_s[idx]);
        for (int idx = 0; idx < k * n; idx++) weight_mem[(wb + idx) % MEMSZ] = 16'(model_w[idx]);
    endtask

    function automatic int ref_c(input int i, input int j, input int k, input int n);
        int sum = 0;
        for (int kk = 0; kk < k; kk++) begin
            if ((model_s[i * k + kk] & 1) != 0) sum += model_w[kk * n + j];
        end
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum;
    endfunction

    task automatic set_job(input int m, input int k, input int n, input int sb, input int wb, input int db);
        bus.m_size               = 10'(m);
        bus.k_size               = 10'(k);
        bus.n_size               = 6'(n);
        bus.spike_start_address  = 14'(sb);
        bus.weight_start_address = 14'(wb);
        bus.dest_start_address   = 14'(db);
    endtask

    // mode 0: one-cycle start; 1: start held for the whole run; 2: extra start pulse mid-run
    task automatic run_job(input string tag, input int m, input int k, input int n,
                           input int sb, input int wb, input int db, input int mode,
                           input int exp_c[$]);
        int cyc;
        int exp_cyc;
        exp_cyc = (m == 0 || k == 0 || n == 0) ? 2 : 2 + m * n * (k + 2);
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        set_job(m, k, n, sb, wb, db);
        bus.start = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (mode != 1) bus.start = 1'b0;
        while (bus.done !== 1'b1 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (mode == 2) bus.start = (cyc == 6) ? 1'b1 : 1'b0;
        end
        bus.start = 1'b0;
        chk({tag, " cycles_to_done"}, cyc, exp_cyc);
        chk({tag, " write_count"}, wr_a.size(), exp_c.size());
        for (int idx = 0; idx < exp_c.size() && idx < wr_a.size(); idx++) begin
            chk($sformatf("%s addr[%0d]", tag, idx), wr_a[idx], (db + idx) % MEMSZ);
            chk($sformatf("%s data[%0d]", tag, idx), wr_d[idx], exp_c[idx]);
        end
    endtask

    initial begin
        int exp_q[$];
        int m, k, n, sb, wb, db;

        vt[0] = '{1, 1, 1, '{1, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0}, '{5, 0, 0, 0}, 5};
        vt[1] = '{1, 1, 1, '{0, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0}, '{0, 0, 0, 0}, 5};
        vt[2] = '{2, 3, 2, '{1, 0, 1, 0, 1, 1}, '{1, 2, 3, 4, -5, 6}, '{-4, 8, -2, 10}, 22};
        vt[3] = '{1, 4, 1, '{1, 1, 1, 1, 0, 0}, '{16000, 16000, 16000, 16000, 0, 0}, '{32767, 0, 0, 0}, 8};
        vt[4] = '{1, 4, 1, '{1, 1, 1, 1, 0, 0}, '{-16000, -16000, -16000, -16000, 0, 0}, '{-32768, 0, 0, 0}, 8};
        vt[5] = '{1, 2, 1, '{3, 2, 0, 0, 0, 0}, '{7, 100, 0, 0, 0, 0}, '{7, 0, 0, 0}, 6};

        for (int a = 0; a < MEMSZ; a++) begin
            spike_mem[a]  = '0;
            weight_mem[a] = '0;
        end

        reset     = 1'b1;
        bus.start = 1'b0;
        set_job(0, 0, 0, 100, 200, 300);
        repeat (3) @(negedge clk);
        chk("reset done", int'(bus.done), 1);
        chk("reset write_en", int'(bus.dest_write_en), 0);
        chk("reset writedata", int'(bus.dest_writedata), 0);
        chk("reset spike_address", int'(bus.spike_address), 100);
        chk("reset weight_address", int'(bus.weight_address), 200);
        chk("reset dest_address", int'(bus.dest_address), 300);
        reset = 1'b0;

        for (int t = 0; t < 6; t++) begin
            for (int idx = 0; idx < 6; idx++) begin
                model_s[idx] = vt[t].s[idx];
                model_w[idx] = vt[t].w[idx];
            end
            sb = 100 + 16 * t;
            wb = 2000 + 16 * t;
            db = (t == 2) ? MEMSZ - 2 : 300;
            load_mem(vt[t].m, vt[t].k, vt[t].n, sb, wb);
            exp_q.delete();
            for (int idx = 0; idx < vt[t].m * vt[t].n; idx++) exp_q.push_back(vt[t].c[idx]);
            chk($sformatf("vec%0d table_cycles", t), 2 + vt[t].m * vt[t].n * (vt[t].k + 2), vt[t].cyc);
            run_job($sformatf("vec%0d", t), vt[t].m, vt[t].k, vt[t].n, sb, wb, db, 0, exp_q);
        end

        // Zero-sized jobs finish quickly with no writes.
        exp_q.delete();
        run_job("zero_n", 2, 3, 0, 100, 200, 300, 0, exp_q);
        run_job("zero_m", 0, 3, 2, 100, 200, 300, 0, exp_q);
        run_job("zero_k", 2, 0, 2, 100, 200, 300, 0, exp_q);

        // Reset during the third MAC cycle of the 2x3x2 job.
        for (int idx = 0; idx < 6; idx++) begin
            model_s[idx] = vt[2].s[idx];
            model_w[idx] = vt[2].w[idx];
        end
        load_mem(2, 3, 2, 500, 600);
        exp_q.delete();
        for (int idx = 0; idx < 4; idx++) exp_q.push_back(vt[2].c[idx]);
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        set_job(2, 3, 2, 500, 600, 700);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset done", int'(bus.done), 1);
        chk("midreset write_en", int'(bus.dest_write_en), 0);
        repeat (4) @(negedge clk);
        chk("midreset stays idle", int'(bus.done), 1);
        chk("midreset no writes", wr_a.size(), 0);
        run_job("after_reset", 2, 3, 2, 500, 600, 700, 0, exp_q);

        // Start held through the run, then a stray start pulse mid-run.
        run_job("held_start", 2, 3, 2, 500, 600, 700, 1, exp_q);
        repeat (3) @(negedge clk);
        chk("held_start single run done", int'(bus.done), 1);
        chk("held_start single run writes", wr_a.size(), 4);
        run_job("midrun_start", 2, 3, 2, 500, 600, 700, 2, exp_q);

        // Randomized jobs, including address wrap and saturation-prone weights.
        for (int r = 0; r < 12; r++) begin
            m  = $urandom_range(1, 3);
            k  = $urandom_range(1, 6);
            n  = $urandom_range(1, 3);
            sb = $urandom_range(0, MEMSZ - 1);
            wb = $urandom_range(0, MEMSZ - 1);
            db = $urandom_range(0, MEMSZ - 1);
            for (int idx = 0; idx < m * k; idx++) model_s[idx] = int'($urandom_range(0, 65535));
            for (int idx = 0; idx < k * n; idx++) begin
                if ($urandom_range(0, 2) == 0) model_w[idx] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(20000, 32767)) : -int'($urandom_range(20000, 32768));
                else model_w[idx] = int'($urandom_range(0, 2000)) - 1000;
            end
            load_mem(m, k, n, sb, wb);
            exp_q.delete();
            for (int i = 0; i < m; i++)
                for (int j = 0; j < n; j++) exp_q.push_back(ref_c(i, j, k, n));
            run_job($sformatf("rand%0d", r), m, k, n, sb, wb, db, 0, exp_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matrix_spike_current.md
Name: matrix_spike_current

Overview:
Producer side of the LIF memory interface. Reads a binary spike matrix S (M x K) and a signed weight matrix W (K x N) from word memories, computes C = S x W as spike-gated accumulation, and writes saturated signed 16-bit currents to a destination matrix. matrix_LIF consumes C as its input-current matrix. Uses the same start/done handshake and address-port style as the other matrix engines.

Parameters:
ADDR_W, 14, width of all memory addresses
DATA_W, 16, memory data width (signed weights and currents)
ACC_W, 26, internal accumulator width (holds 1023 x 2^15 without overflow)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  launch request, sampled only in IDLE
done  output  1  1 = idle/finished, 0 = busy
spike_start_address  input  ADDR_W  base of S, row-major: S[i][k] at base + i*K + k
weight_start_address  input  ADDR_W  base of W, row-major: W[k][j] at base + k*N + j
dest_start_address  input  ADDR_W  base of C, row-major: C[i][j] at base + i*N + j
m_size  input  10  M, spike rows
k_size  input  10  K, shared dimension
n_size  input  6  N, weight columns
spike_address  output reg  ADDR_W  S read address
spike_readdata  input  DATA_W  S word; only bit 0 is used
weight_address  output reg  ADDR_W  W read address
weight_readdata  input signed  DATA_W  W word
dest_address  output reg  ADDR_W  C write address
dest_writedata  output reg signed  DATA_W  C word
dest_write_en  output reg  1  C write strobe, one cycle per element

Behaviour:
- Memories are synchronous read: readdata is valid in the cycle after the address register changes (one-cycle latency).
- Reset values: done=1, dest_write_en=0, dest_writedata=0, state=IDLE. spike_address, weight_address and dest_address are loaded from their start addresses. Accumulator and i/j/k counters = 0.
- IDLE: done=1, write_en=0. On start=1, go to LOAD and set done=0 on the next edge. If start is held, a new run launches only after the current run returns to IDLE.
- LOAD (1 cycle): latch the sizes and bases. If M, K or N is 0, go to IDLE with done=1 and perform no writes. Otherwise set i=j=k=0, acc=0, issue S/W addresses for (i, j, k=0), and go to MAC.
- MAC (K cycles): each cycle, issue the next k address pair while k < K-1. In the same cycle, accumulate the data returned for the previous issue: acc += spike bit0 ? sign-extended weight : 0. The first MAC cycle accumulates nothing, because a one-cycle valid pipe gates accumulation. After K-1 issues, go to DRAIN.
- DRAIN (1 cycle): accumulate the final returned pair.
- WRITE (1 cycle): dest_address = base + i*N + j. Set dest_writedata = acc saturated to [-32768, 32767] and dest_write_en=1 for this cycle only. Then clear acc and advance j; on j = N-1, wrap j to 0 and advance i. If this was element (M-1, N-1), go to IDLE with done=1 on the next edge. Otherwise issue addresses for the next element and re-enter MAC.
- Throughput: exactly K+2 cycles per output element. Total busy time from start sampled to done=1 is 1 + M*N*(K+2) + 1 cycles.
- Address arithmetic: compute via running row/column base registers (add K, add N), not multipliers. Addresses wrap modulo 2^ADDR_W without error.
- start while busy: ignored. Reset mid-run: back to IDLE immediately at the edge, write_en=0, no partial write. Spike words other than 0/1: only bit 0 is significant.

Decomposition:
- Shared package snn_mem_pkg: ADDR_W, DATA_W, state encoding (IDLE, LOAD, MAC, DRAIN, WRITE), and the saturation constants SAT_MAX=32767, SAT_MIN=-32768.
- One sub-module: spike_mac_sat. It holds the ACC_W accumulator with clear, gated add and valid pipe, plus the combinational saturate-to-DATA_W output.
- Counters and address generation stay in the top module.

Test Plan:
1. M=K=N=1, S=[1], W=[5] -> single write C[0]=5; done rises 5 cycles after start is sampled. Repeat with S=[0] -> C[0]=0.
2. M=2, K=3, N=2, S rows [1,0,1] and [0,1,1], W rows [1,2], [3,4], [-5,6] -> C = [-4,8], [-2,10], written in row-major order at dest base..base+3, with exactly 4 write_en pulses.
3. Saturation: M=N=1, K=4, all spikes 1, W=16000 each -> C=32767. With W=-16000 each -> C=-32768.
4. Zero size: N=0 with start -> done returns to 1 within 3 cycles, no dest_write_en pulse.
5. Reset asserted in the 3rd MAC cycle of test 2 -> next cycle state=IDLE, done=1, no write. A fresh start then reproduces the test 2 results exactly.
6. Start held high for the whole run of test 2 -> exactly one run per IDLE visit. A start pulse mid-run has no effect on addresses or output values.
